// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode/execute controller: widths, opcodes,
// controller states and instruction-word field helpers.
package cpu_pkg;

  localparam int ADDR_W    = 8;
  localparam int WORD_W    = 10;
  localparam int MEM_DEPTH = 16;

  localparam logic [1:0] OPC_HLT  = 2'b00;
  localparam logic [1:0] OPC_MOVR = 2'b01;
  localparam logic [1:0] OPC_LDI  = 2'b10;
  localparam logic [1:0] OPC_LDA  = 2'b11;

  localparam int OPC_HI  = 9;
  localparam int OPC_LO  = 8;
  localparam int OPND_HI = 7;
  localparam int OPND_LO = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    DIR    = 3'd3,
    IND1   = 3'd4,
    IND2   = 3'd5,
    HALT   = 3'd6
  } state_t;

  function automatic logic [1:0] getOpc(input logic [WORD_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [ADDR_W-1:0] getOpnd(input logic [WORD_W-1:0] word);
    return word[OPND_HI:OPND_LO];
  endfunction

  // Only the lowest MEM_DEPTH addresses are backed by real memory words.
  function automatic logic isOutOfRange(input logic [ADDR_W-1:0] addr);
    return addr >= ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/fetch_exec_ctrl.sv
// Fetch/decode/execute controller: sequences PC -> memory -> IR and executes
// HLT/MOVR/LDI/LDA against an asynchronously read 16x10 memory.
module fetch_exec_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rw,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_mar,
  output logic [WORD_W-1:0] o_ir,
  output logic [WORD_W-1:0] o_mbr,
  output logic [ADDR_W-1:0] o_reg_r,
  output logic [ADDR_W-1:0] o_reg_a,
  output logic              o_busy,
  output logic              o_instr_done,
  output logic              o_halted,
  output logic              o_addr_err
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_bad;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_mbr;
  logic [ADDR_W-1:0] r_r;
  logic [ADDR_W-1:0] r_a;
  logic              r_done;
  logic              r_err;

  // The memory address is a pure function of state, so the memory's async read
  // data is consumed in the same cycle it is addressed.
  always_comb begin
    w_next     = r_state;
    w_addr     = '0;
    w_addr_bad = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = FETCH;
      end
      FETCH: begin
        w_addr     = r_pc;
        w_addr_bad = isOutOfRange(r_pc);
        w_next     = w_addr_bad ? HALT : DECODE;
      end
      DECODE: begin
        w_addr = r_pc;
        case (getOpc(r_ir))
          OPC_MOVR: w_next = FETCH;
          OPC_LDI:  w_next = DIR;
          OPC_LDA:  w_next = IND1;
          default:  w_next = HALT;
        endcase
      end
      DIR: begin
        w_addr     = getOpnd(r_ir);
        w_addr_bad = isOutOfRange(w_addr);
        w_next     = w_addr_bad ? HALT : FETCH;
      end
      IND1: begin
        w_addr     = getOpnd(r_ir);
        w_addr_bad = isOutOfRange(w_addr);
        w_next     = w_addr_bad ? HALT : IND2;
      end
      IND2: begin
        w_addr     = r_mar;
        w_addr_bad = isOutOfRange(w_addr);
        w_next     = w_addr_bad ? HALT : FETCH;
      end
      HALT: begin
        w_addr = r_pc;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_mar   <= '0;
      r_ir    <= '0;
      r_mbr   <= '0;
      r_r     <= '0;
      r_a     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      // An out-of-range access only raises the sticky error; no register moves.
      if (w_addr_bad) begin
        r_err <= 1'b1;
      end else begin
        case (r_state)
          FETCH: begin
            r_ir <= i_mem_rdata;
            r_pc <= r_pc + 1'b1;
          end
          DECODE: begin
            if (getOpc(r_ir) == OPC_MOVR) begin
              r_r    <= getOpnd(r_ir);
              r_done <= 1'b1;
            end
          end
          DIR: begin
            r_mbr  <= i_mem_rdata;
            r_a    <= getOpnd(i_mem_rdata);
            r_done <= 1'b1;
          end
          IND1: begin
            r_mbr <= i_mem_rdata;
            r_mar <= getOpnd(i_mem_rdata);
          end
          IND2: begin
            r_mbr  <= i_mem_rdata;
            r_a    <= getOpnd(i_mem_rdata);
            r_done <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_mem_addr   = w_addr;
  assign o_mem_rw     = 1'b0;
  assign o_mem_wdata  = '0;
  assign o_pc         = r_pc;
  assign o_mar        = r_mar;
  assign o_ir         = r_ir;
  assign o_mbr        = r_mbr;
  assign o_reg_r      = r_r;
  assign o_reg_a      = r_a;
  assign o_busy       = (r_state != IDLE) && (r_state != HALT);
  assign o_instr_done = r_done;
  assign o_halted     = (r_state == HALT);
  assign o_addr_err   = r_err;

endmodule
